// File: rtl/systolic_tile_sequencer_if.sv
// Bus bundle between the tile sequencer and the blocks it talks to.
//   scheduler side : start, cfg_num_vec (in to sequencer); busy, done (out)
//   array side     : mac_control (out)
//   buffer side    : wt_rd_en/wt_rd_addr, data_rd_en/data_rd_addr,
//                    out_wr_en/out_wr_addr (out)
// The sequencer connects through the slave modport. The scheduler, or a bench,
// drives the bundle through the master modport.
interface systolic_tile_sequencer_if #(
    parameter int VEC_W   = 16,
    parameter int WADDR_W = 4
);
    logic               start;
    logic [VEC_W-1:0]   cfg_num_vec;
    logic               busy;
    logic               done;
    logic               mac_control;
    logic               wt_rd_en;
    logic [WADDR_W-1:0] wt_rd_addr;
    logic               data_rd_en;
    logic [VEC_W-1:0]   data_rd_addr;
    logic               out_wr_en;
    logic [VEC_W-1:0]   out_wr_addr;

    modport master (
        output start, cfg_num_vec,
        input  busy, done, mac_control,
        input  wt_rd_en, wt_rd_addr, data_rd_en, data_rd_addr,
        input  out_wr_en, out_wr_addr
    );

    modport slave (
        input  start, cfg_num_vec,
        output busy, done, mac_control,
        output wt_rd_en, wt_rd_addr, data_rd_en, data_rd_addr,
        output out_wr_en, out_wr_addr
    );
endinterface

// File: rtl/systolic_tile_sequencer.sv
// Sequences one tile through a weight-stationary MAC array.
//
// Tile flow:
//   1. Shift ROWS weight rows into the array, last row first.
//   2. Hold one latch cycle.
//   3. Stream n_vec activation vectors and write the results back.
//
// Ports:
//   clk    : clock
//   rst_n  : synchronous active-low reset
//   bus    : slave modport of systolic_tile_sequencer_if, which carries:
//            start/cfg_num_vec in; busy/done out;
//            mac_control out;
//            weight/activation read strobes and addresses;
//            result write strobe and address.
//
// Every output is a register. The register is loaded from the next state
// and the next counter value, so outputs line up with the state they describe.
module systolic_tile_sequencer #(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int OUT_LAT = ROWS + COLS,
    parameter int VEC_W   = 16,
    parameter int WADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input logic                      clk,
    input logic                      rst_n,
    systolic_tile_sequencer_if.slave bus
);
    // The counter is one bit wider than VEC_W, so n_vec + OUT_LAT - 1 cannot wrap.
    localparam int CW = VEC_W + 1;

    typedef enum logic [2:0] {IDLE, LOAD, LATCH, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [VEC_W-1:0] n_vec, n_vec_nxt;
    logic [CW-1:0]    run_last;

    logic               busy_nxt, done_nxt, mac_nxt;
    logic               wt_en_nxt, data_en_nxt, out_en_nxt;
    logic [WADDR_W-1:0] wt_addr_nxt;
    logic [VEC_W-1:0]   data_addr_nxt, out_addr_nxt;

    assign run_last = {1'b0, n_vec} + CW'(OUT_LAT - 1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        n_vec_nxt = n_vec;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                    n_vec_nxt = bus.cfg_num_vec;
                end
            end
            LOAD: begin
                if (cnt == CW'(ROWS)) begin
                    state_nxt = LATCH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            LATCH: begin
                // With no vectors to stream, the tile only needs the weights loaded.
                state_nxt = (n_vec == '0) ? DONE : RUN;
                cnt_nxt   = '0;
            end
            RUN: begin
                if (cnt == run_last) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt      = (state_nxt != IDLE);
        done_nxt      = (state_nxt == DONE);
        mac_nxt       = 1'b0;
        wt_en_nxt     = 1'b0;
        wt_addr_nxt   = '0;
        data_en_nxt   = 1'b0;
        data_addr_nxt = '0;
        out_en_nxt    = 1'b0;
        out_addr_nxt  = '0;
        if (state_nxt == LOAD) begin
            wt_en_nxt = (cnt_nxt < CW'(ROWS));
            if (wt_en_nxt) begin
                wt_addr_nxt = WADDR_W'(CW'(ROWS - 1) - cnt_nxt);
            end
            // Shifting starts one cycle after the first read, because of the buffer read latency.
            mac_nxt = (cnt_nxt != '0);
        end
        if (state_nxt == RUN) begin
            data_en_nxt = (cnt_nxt < {1'b0, n_vec_nxt});
            if (data_en_nxt) begin
                data_addr_nxt = VEC_W'(cnt_nxt);
            end
            out_en_nxt = (cnt_nxt >= CW'(OUT_LAT));
            if (out_en_nxt) begin
                out_addr_nxt = VEC_W'(cnt_nxt - CW'(OUT_LAT));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            n_vec            <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.mac_control  <= 1'b0;
            bus.wt_rd_en     <= 1'b0;
            bus.wt_rd_addr   <= '0;
            bus.data_rd_en   <= 1'b0;
            bus.data_rd_addr <= '0;
            bus.out_wr_en    <= 1'b0;
            bus.out_wr_addr  <= '0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            n_vec            <= n_vec_nxt;
            bus.busy         <= busy_nxt;
            bus.done         <= done_nxt;
            bus.mac_control  <= mac_nxt;
            bus.wt_rd_en     <= wt_en_nxt;
            bus.wt_rd_addr   <= wt_addr_nxt;
            bus.data_rd_en   <= data_en_nxt;
            bus.data_rd_addr <= data_addr_nxt;
            bus.out_wr_en    <= out_en_nxt;
            bus.out_wr_addr  <= out_addr_nxt;
        end
    end
endmodule
